// File: rtl/ram_port_ctrl_if.sv
// Request/response handshake bundle between a CPU/DMA initiator and the RAM
// port controller. Valid/ready rule for both channels: a transfer happens on
// the rising clock edge where valid and ready are both high; the source holds
// its payload stable while valid is high and ready is low.
interface ram_port_ctrl_if #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRWIDTH = 8
);
  logic                 req_valid;
  logic                 req_ready;
  logic                 req_write;
  logic [ADDRWIDTH-1:0] req_addr;
  logic [DATAWIDTH-1:0] req_data;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [DATAWIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_write, req_addr, req_data, rsp_ready,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_write, req_addr, req_data, rsp_ready,
    output req_ready, rsp_valid, rsp_data
  );
endinterface

// File: rtl/ram_port_ctrl.sv
// Initiator side of one synchronous RAM port: turns a request stream into
// registered RAM cycles, returns read data through a credit-protected
// first-word-fall-through FIFO, and offers a bulk-init sequencer.
module ram_port_ctrl #(
  parameter int DATAWIDTH  = 8,
  parameter int ADDRWIDTH  = 8,
  parameter int RD_LATENCY = 2,
  parameter int RSP_DEPTH  = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  ram_port_ctrl_if.slave       io_bus,
  input  logic                 i_init_start,
  input  logic [DATAWIDTH-1:0] i_init_value,
  output logic                 o_init_busy,
  output logic                 o_init_done,
  output logic                 o_ram_we,
  output logic                 o_ram_re,
  output logic [ADDRWIDTH-1:0] o_ram_addr,
  output logic [DATAWIDTH-1:0] o_ram_din,
  input  logic [DATAWIDTH-1:0] i_ram_dout,
  output logic [1:0]           o_dbg_state
);

  localparam int PW = $clog2(RSP_DEPTH);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  localparam int SW = CW + 1;
  localparam logic [ADDRWIDTH-1:0] LAST_ADDR = '1;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_DRAIN = 2'd1,
    ST_INIT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic                 w_req_ready;
  logic                 w_accept;
  logic                 w_rd_accept;
  logic                 w_init_go;
  logic                 w_init_last;
  logic [RD_LATENCY:0]  r_rd_sr;
  logic [SW-1:0]        w_inflight;
  logic [SW-1:0]        w_credit_used;
  logic [CW-1:0]        r_count;
  logic [PW-1:0]        r_wr_ptr;
  logic [PW-1:0]        r_rd_ptr;
  logic [DATAWIDTH-1:0] r_fifo [RSP_DEPTH];
  logic                 w_push;
  logic                 w_pop;
  logic                 w_rsp_valid;
  logic                 r_ram_we;
  logic                 r_ram_re;
  logic [ADDRWIDTH-1:0] r_ram_addr;
  logic [DATAWIDTH-1:0] r_ram_din;
  logic [ADDRWIDTH-1:0] r_init_addr;
  logic [DATAWIDTH-1:0] r_init_value;
  logic                 r_init_done;

  assign w_accept    = io_bus.req_valid & w_req_ready;
  assign w_rd_accept = w_accept & ~io_bus.req_write;
  assign w_init_go   = (r_state == ST_RUN) & i_init_start;
  assign w_init_last = (r_state == ST_INIT) & (r_init_addr == LAST_ADDR);
  // The oldest tracker stage lines up with valid RAM output data.
  assign w_push      = r_rd_sr[RD_LATENCY];
  assign w_rsp_valid = (r_count != '0);
  assign w_pop       = w_rsp_valid & io_bus.rsp_ready;

  // Count reads still travelling through the RAM pipeline and total credits used.
  always_comb begin
    w_inflight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      w_inflight = w_inflight + SW'(r_rd_sr[i]);
    end
    w_credit_used = w_inflight + SW'(r_count);
  end

  // FSM state register.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_state <= ST_RUN;
    else       r_state <= w_next_state;
  end

  // FSM next-state logic: RUN -> DRAIN on init request, DRAIN waits for the
  // pipeline to empty, INIT walks every address once.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      ST_RUN:   if (i_init_start)              w_next_state = ST_DRAIN;
      ST_DRAIN: if (w_inflight == '0)          w_next_state = ST_INIT;
      ST_INIT:  if (r_init_addr == LAST_ADDR)  w_next_state = ST_RUN;
      default:                                 w_next_state = ST_RUN;
    endcase
  end

  // FSM outputs. r_ram_re doubles as an out-of-reset flag so ReqReady is 0
  // while reset is held; the credit term never looks at ReqValid.
  always_comb begin
    w_req_ready = (r_state == ST_RUN) && r_ram_re &&
                  (w_credit_used < SW'(RSP_DEPTH));
    o_init_busy = (r_state != ST_RUN);
    o_dbg_state = r_state;
  end

  // Registered RAM drive: accepted request or init write, one per cycle.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_ram_we   <= 1'b0;
      r_ram_re   <= 1'b0;
      r_ram_addr <= '0;
      r_ram_din  <= '0;
    end else begin
      r_ram_re <= 1'b1;
      if (w_accept) begin
        r_ram_we   <= io_bus.req_write;
        r_ram_addr <= io_bus.req_addr;
        r_ram_din  <= io_bus.req_data;
      end else if (r_state == ST_INIT) begin
        r_ram_we   <= 1'b1;
        r_ram_addr <= r_init_addr;
        r_ram_din  <= r_init_value;
      end else begin
        r_ram_we   <= 1'b0;
      end
    end
  end

  // Init sequencer: capture fill value on start, step the address in INIT,
  // and pulse done alongside the final write.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_init_addr  <= '0;
      r_init_value <= '0;
      r_init_done  <= 1'b0;
    end else begin
      r_init_done <= w_init_last;
      if (w_init_go) begin
        r_init_value <= i_init_value;
        r_init_addr  <= '0;
      end else if (r_state == ST_INIT) begin
        r_init_addr  <= r_init_addr + ADDRWIDTH'(1);
      end
    end
  end

  // In-flight read tracker: one valid bit per pipeline stage.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) r_rd_sr <= '0;
    else       r_rd_sr <= {r_rd_sr[RD_LATENCY-1:0], w_rd_accept};
  end

  // Response FIFO storage and pointers; push and pop may share an edge.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
      for (int i = 0; i < RSP_DEPTH; i++) r_fifo[i] <= '0;
    end else begin
      if (w_push) begin
        r_fifo[r_wr_ptr] <= i_ram_dout;
        r_wr_ptr         <= r_wr_ptr + PW'(1);
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  assign io_bus.req_ready = w_req_ready;
  assign io_bus.rsp_valid = w_rsp_valid;
  assign io_bus.rsp_data  = r_fifo[r_rd_ptr];
  assign o_init_done      = r_init_done;
  assign o_ram_we         = r_ram_we;
  assign o_ram_re         = r_ram_re;
  assign o_ram_addr       = r_ram_addr;
  assign o_ram_din        = r_ram_din;

endmodule

// File: tb/tb_ram_port_ctrl.sv
// Directed bench for ram_port_ctrl with a two-stage behavioural block RAM,
// a reference memory and an expected-response queue.
module tb_ram_port_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       init_start;
  logic [7:0] init_value;
  logic       init_busy, init_done;
  logic       ram_we, ram_re;
  logic [7:0] ram_addr, ram_din, ram_dout;
  logic [1:0] dbg_state;

  ram_port_ctrl_if #(.DATAWIDTH(8), .ADDRWIDTH(8)) bus ();

  ram_port_ctrl #(.DATAWIDTH(8), .ADDRWIDTH(8), .RD_LATENCY(2), .RSP_DEPTH(4)) dut (
    .i_clk(clk), .i_rst(rst), .io_bus(bus),
    .i_init_start(init_start), .i_init_value(init_value),
    .o_init_busy(init_busy), .o_init_done(init_done),
    .o_ram_we(ram_we), .o_ram_re(ram_re), .o_ram_addr(ram_addr),
    .o_ram_din(ram_din), .i_ram_dout(ram_dout), .o_dbg_state(dbg_state)
  );

  // Clock and watchdog
  always #5 clk = ~clk;

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Behavioural RAM: registered address read, then output register on ram_re.
  logic [7:0] ram_mem [256];
  logic [7:0] ram_stage = 8'h00;
  logic       ram_loaded = 1'b0;
  initial ram_dout = 8'h00;
  always @(posedge clk) begin
    if (!ram_loaded) begin
      for (int i = 0; i < 256; i++) ram_mem[i] <= 8'(i) ^ 8'h3C;
      ram_loaded <= 1'b1;
    end else begin
      if (ram_we) ram_mem[ram_addr] <= ram_din;
      ram_stage <= ram_mem[ram_addr];
      if (ram_re) ram_dout <= ram_stage;
    end
  end

  // Scoreboard state
  logic [7:0] ref_mem [256];
  logic [7:0] exp_q [$];
  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int n_done   = 0;
  int n_rsp    = 0;
  int n_reads  = 0;
  int acc      = 0;
  bit rand_rdy = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Response monitor: a pop happens on the next edge when valid & ready now.
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst && bus.rsp_valid && bus.rsp_ready) begin
      e = 8'hxx;
      if (exp_q.size() != 0) e = exp_q.pop_front();
      n_rsp++;
      check("rsp_data", {24'b0, bus.rsp_data}, {24'b0, e});
    end
    if (!rst && init_done) n_done++;
  end

  // Driver tasks
  task automatic tick();
    @(posedge clk);
    #1;
    if (rand_rdy) bus.rsp_ready = ($urandom_range(0, 1) == 1);
  endtask

  task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d);
    int w = 0;
    bus.req_valid = 1'b1;
    bus.req_write = wr;
    bus.req_addr  = a;
    bus.req_data  = d;
    while (!bus.req_ready && w < 60) begin
      tick();
      w++;
    end
    check("req_ready_wait", {31'b0, bus.req_ready}, 32'd1);
    if (bus.req_ready) begin
      if (wr) ref_mem[a] = d;
      else begin
        exp_q.push_back(ref_mem[a]);
        n_reads++;
      end
      tick();
    end
    bus.req_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int w = 0;
    while (exp_q.size() != 0 && w < 300) begin
      tick();
      w++;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  // Keep a read request up, advancing the address on every accept.
  task automatic stream_reads(input int max_cyc);
    int cyc = 0;
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'(acc);
    while (acc < 6 && cyc < max_cyc) begin
      if (bus.req_ready) begin
        exp_q.push_back(ref_mem[acc]);
        n_reads++;
        tick();
        acc++;
        bus.req_addr = 8'(acc);
      end else begin
        tick();
      end
      cyc++;
    end
    bus.req_valid = 1'b0;
  endtask

  initial begin
    int nwr, gaps, bad, busy_rdy, w, done_before;
    bit done, started, found;

    rst = 1'b1;
    init_start = 1'b0;
    init_value = 8'h00;
    bus.req_valid = 1'b0;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h00;
    bus.req_data  = 8'h00;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'(i) ^ 8'h3C;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_ram_we",    {31'b0, ram_we},        0);
    check("rst_ram_re",    {31'b0, ram_re},        0);
    check("rst_ram_addr",  {24'b0, ram_addr},      0);
    check("rst_init_busy", {31'b0, init_busy},     0);
    check("rst_req_ready", {31'b0, bus.req_ready}, 0);
    check("rst_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    check("rst_state",     {30'b0, dbg_state},     0);
    rst = 1'b0;
    tick();
    check("post_rst_ram_re",    {31'b0, ram_re},        1);
    check("post_rst_req_ready", {31'b0, bus.req_ready}, 1);

    // T1: write then read same address, read latency to RspValid
    bus.rsp_ready = 1'b1;
    send(1'b1, 8'h10, 8'h5A);
    check("t1_wr_we",   {31'b0, ram_we},   1);
    check("t1_wr_addr", {24'b0, ram_addr}, 32'h10);
    check("t1_wr_din",  {24'b0, ram_din},  32'h5A);
    send(1'b0, 8'h10, 8'h00);
    check("t1_rd_we", {31'b0, ram_we}, 0);
    tick();
    check("t1_valid_e1", {31'b0, bus.rsp_valid}, 0);
    tick();
    check("t1_valid_e2", {31'b0, bus.rsp_valid}, 0);
    tick();
    check("t1_valid_e3", {31'b0, bus.rsp_valid}, 1);
    check("t1_data",     {24'b0, bus.rsp_data},  32'h5A);
    wait_drain();

    // T2: credit limit with a stalled consumer
    bus.rsp_ready = 1'b0;
    acc = 0;
    stream_reads(20);
    check("t2_accepts_stalled", acc, 4);
    check("t2_ready_low",  {31'b0, bus.req_ready}, 0);
    check("t2_rsp_valid",  {31'b0, bus.rsp_valid}, 1);
    bus.rsp_ready = 1'b1;
    stream_reads(40);
    check("t2_accepts_all", acc, 6);
    wait_drain();

    // T3: init started on the same edge as a read, with another read in flight
    send(1'b0, 8'h10, 8'h00);
    bus.req_valid = 1'b1;
    bus.req_write = 1'b0;
    bus.req_addr  = 8'h20;
    init_start = 1'b1;
    init_value = 8'hA5;
    check("t3_ready_at_start", {31'b0, bus.req_ready}, 1);
    exp_q.push_back(ref_mem[8'h20]);
    n_reads++;
    tick();
    bus.req_valid = 1'b0;
    init_start = 1'b0;
    init_value = 8'h00;
    check("t3_busy",      {31'b0, init_busy},     1);
    check("t3_state",     {30'b0, dbg_state},     1);
    check("t3_ready_off", {31'b0, bus.req_ready}, 0);
    nwr = 0; gaps = 0; bad = 0; busy_rdy = 0; w = 0;
    done = 0; started = 0;
    while (!done && w < 400) begin
      tick();
      w++;
      if (ram_we) begin
        started = 1;
        if (ram_addr != 8'(nwr)) bad++;
        nwr++;
      end else if (started) begin
        gaps++;
      end
      if (init_busy && bus.req_ready) busy_rdy++;
      if (init_done) done = 1;
    end
    check("t3_done_seen",  {31'b0, done}, 1);
    check("t3_writes",     nwr, 256);
    check("t3_addr_order", bad, 0);
    check("t3_gaps",       gaps, 0);
    check("t3_ready_busy", busy_rdy, 0);
    check("t3_old_reads",  exp_q.size(), 0);
    check("t3_busy_off",   {31'b0, init_busy}, 0);
    tick();
    check("t3_done_pulse", {31'b0, init_done}, 0);
    for (int i = 0; i < 256; i++) ref_mem[i] = 8'hA5;
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'hFF, 8'h00);
    wait_drain();

    // T4: reset in the middle of init
    done_before = n_done;
    init_start = 1'b1;
    init_value = 8'h3C;
    tick();
    init_start = 1'b0;
    found = 0; w = 0;
    while (!found && w < 300) begin
      tick();
      w++;
      if (ram_we && ram_addr == 8'h40) found = 1;
    end
    check("t4_reached_40", {31'b0, found}, 1);
    rst = 1'b1;
    #1;
    check("t4_ram_we",    {31'b0, ram_we},        0);
    check("t4_ram_addr",  {24'b0, ram_addr},      0);
    check("t4_ram_din",   {24'b0, ram_din},       0);
    check("t4_ram_re",    {31'b0, ram_re},        0);
    check("t4_busy",      {31'b0, init_busy},     0);
    check("t4_done",      {31'b0, init_done},     0);
    check("t4_req_ready", {31'b0, bus.req_ready}, 0);
    check("t4_rsp_valid", {31'b0, bus.rsp_valid}, 0);
    exp_q.delete();
    tick();
    tick();
    rst = 1'b0;
    tick();
    tick();
    check("t4_no_done", n_done, done_before);
    for (int i = 0; i < 8'h40; i++) ref_mem[i] = 8'h3C;
    send(1'b0, 8'h00, 8'h00);
    send(1'b0, 8'h3F, 8'h00);
    send(1'b0, 8'h40, 8'h00);
    send(1'b0, 8'hC0, 8'h00);
    wait_drain();

    // T5: pop and push on the same edge with one entry held
    bus.rsp_ready = 1'b0;
    send(1'b0, 8'h3F, 8'h00);
    w = 0;
    while (!bus.rsp_valid && w < 20) begin
      tick();
      w++;
    end
    check("t5_first_held", {31'b0, bus.rsp_valid}, 1);
    send(1'b0, 8'h40, 8'h00);
    tick();
    tick();
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t5_valid_after_swap", {31'b0, bus.rsp_valid}, 1);
    check("t5_data_after_swap",  {24'b0, bus.rsp_data},  32'hA5);
    tick();
    check("t5_still_one", {31'b0, bus.rsp_valid}, 1);
    bus.rsp_ready = 1'b1;
    tick();
    bus.rsp_ready = 1'b0;
    check("t5_empty", {31'b0, bus.rsp_valid}, 0);

    // T6: random read/write mix on a small address window, random RspReady
    rand_rdy = 1;
    for (int k = 0; k < 400; k++) begin
      send(1'($urandom_range(0, 1)), 8'($urandom_range(0, 15)), 8'($urandom_range(0, 255)));
    end
    rand_rdy = 0;
    bus.rsp_ready = 1'b1;
    wait_drain();
    tick();
    tick();
    check("t6_rsp_count", n_rsp, n_reads);
    check("t6_final_valid", {31'b0, bus.rsp_valid}, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
